md_issue_ctrl: RTL

E-stage issue controller sitting directly upstream of the multiply/divide unit. It filters the E-stage MD opcode into the unit's one-cycle OP input and drives the operands. It produces the D-stage stall for the MD structural hazard, including the cycle before the unit's registered busy rises, and returns HI/LO for mfhi/mflo. A latency checker and a start counter support verification and performance bring-up.

---
 rtl/md_issue_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: opcode filtering, operand drive,
// D-stage structural stall, HI/LO read-back, plus a busy-latency checker and start counter.
module md_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_md_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_md_use,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic [3:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall_d,
    output logic [31:0] e_md_result,
    output logic        md_err,
    output logic [15:0] md_starts
);

    // state | meaning
    // IDLE  | no multiply/divide outstanding
    // MUL   | mult/multu issued, counting busy cycles (expect 5)
    // DIV   | div/divu issued, counting busy cycles (expect 10)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    logic [1:0] state;
    logic [3:0] cnt;

    logic is_start_op;
    logic is_write_op;
    logic start_now;
    logic write_now;
    logic start_is_div;
    logic issue_blocked;
    logic lat_bad;

    assign is_start_op   = (e_md_op >= 4'd1) && (e_md_op <= 4'd4);
    assign is_write_op   = (e_md_op == 4'd5) || (e_md_op == 4'd6);
    assign start_now     = e_valid && is_start_op && !md_busy;
    assign write_now     = e_valid && is_write_op && !md_busy;
    assign start_is_div  = (e_md_op == 4'd3) || (e_md_op == 4'd4);
    assign issue_blocked = e_valid && (is_start_op || is_write_op) && md_busy;

    assign md_op = (start_now || write_now) ? e_md_op : 4'd0;
    assign md_a  = e_rs;
    assign md_b  = e_rt;

    // start_now covers the cycle before the unit's registered busy is visible
    assign stall_d = d_md_use && (start_now || md_busy);

    always_comb begin
        e_md_result = 32'd0;
        if (e_md_op == 4'd7) begin
            e_md_result = md_hi;
        end else if (e_md_op == 4'd8) begin
            e_md_result = md_lo;
        end
    end

    assign lat_bad = !md_busy &&
                     (((state == MUL) && (cnt != MUL_LAT)) ||
                      ((state == DIV) && (cnt != DIV_LAT)));

    // A start in the completion cycle (busy already low) re-enters MUL/DIV directly;
    // starts cannot otherwise occur outside IDLE because start_now requires !md_busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_now) begin
                        state <= start_is_div ? DIV : MUL;
                        cnt   <= 4'd0;
                    end
                end
                MUL, DIV: begin
                    if (md_busy) begin
                        if (cnt != 4'd15) begin
                            cnt <= cnt + 4'd1;
                        end
                    end else if (start_now) begin
                        state <= start_is_div ? DIV : MUL;
                        cnt   <= 4'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_err <= 1'b0;
        end else if (lat_bad || issue_blocked) begin
            md_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_starts <= 16'd0;
        end else if (start_now) begin
            md_starts <= md_starts + 16'd1;
        end
    end

endmodule
